// File: rtl/retire_mon_pkg.sv
// Shared definitions for the retire monitor: opcode classes, read-select codes,
// state encoding and the saturating-increment helper.
package retire_mon_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Counter select codes double as indices into the counter array.
  localparam logic [3:0] SEL_CYCLES   = 4'd0;
  localparam logic [3:0] SEL_RETIRED  = 4'd1;
  localparam logic [3:0] SEL_R        = 4'd2;
  localparam logic [3:0] SEL_I        = 4'd3;
  localparam logic [3:0] SEL_LOAD     = 4'd4;
  localparam logic [3:0] SEL_STORE    = 4'd5;
  localparam logic [3:0] SEL_BRANCH   = 4'd6;
  localparam logic [3:0] SEL_TAKEN    = 4'd7;
  localparam logic [3:0] SEL_OTHER    = 4'd8;
  localparam logic [3:0] SEL_MISMATCH = 4'd9;
  localparam logic [3:0] SEL_STATE    = 4'd10;
  localparam int         NUM_CNT      = 10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_HUNG   = 2'd2
  } mon_state_e;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/retire_mon_trace_buf.sv
// Circular buffer of taken branches; entry 0 is the most recent push.
// Oldest entries are overwritten once DEPTH pushes have accumulated.
module retire_mon_trace_buf #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [2*XLEN-1:0]         push_data,
  input  logic [$clog2(DEPTH)-1:0]  rd_idx,
  output logic [2*XLEN-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;

  // NOTE: the storage array has no reset; count gates every read, so stale
  // entries are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
        if (count != (IDX_W+1)'(DEPTH)) count <= count + (IDX_W+1)'(1);
      end
      rd_data <= ({1'b0, rd_idx} < count) ? mem[wr_ptr - IDX_W'(1) - rd_idx] : '0;
    end
  end

endmodule

// File: rtl/retire_monitor.sv
// Passive retire monitor: classifies each executed instruction, keeps saturating
// counters, detects halt/hang. Define RETIRE_MON_TRACE_EN to add the branch trace.
module retire_monitor #(
  parameter int XLEN        = 64,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [XLEN-1:0]                 pc_in,
  input  logic [31:0]                     instr_in,
  input  logic                            reg_write_en_in,
  input  logic                            mem_write_in,
  input  logic                            branch_in,
  input  logic [3:0]                      rd_sel,
  output logic [CNT_W-1:0]                rd_data,
  output logic                            halted,
  output logic                            hung,
  input  logic [$clog2(TRACE_DEPTH)-1:0]  tr_idx,
  output logic [2*XLEN-1:0]               tr_data,
  output logic [$clog2(TRACE_DEPTH):0]    tr_count
);

  import retire_mon_pkg::*;

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  mon_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [NUM_CNT-1:0] inc;
  logic               pending_q, pending_d;
  logic [XLEN-1:0]    src_q, src_d;
  logic [XLEN-1:0]    prev_pc_q;
  logic               prev_valid_q;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               push;
  logic [CNT_W-1:0]   rd_mux;
  logic [6:0]         opcode;
  logic               pc_same;

  assign opcode  = instr_in[6:0];
  assign pc_same = prev_valid_q && (pc_in == prev_pc_q);
  assign halted  = (state_q == ST_HALTED);
  assign hung    = (state_q == ST_HUNG);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    inc       = '0;
    push      = 1'b0;
    pending_d = pending_q;
    src_d     = src_q;
    stall_d   = stall_q;
    if (state_q == ST_RUN) begin
      inc[SEL_CYCLES] = 1'b1;
      // A pending branch resolves on the very next sample, even the halting one.
      if (pending_q) begin
        pending_d = 1'b0;
        if (pc_in != src_q + XLEN'(4)) begin
          inc[SEL_TAKEN] = 1'b1;
          push           = 1'b1;
        end
      end
      if (instr_in == 32'd0) begin
        state_d = ST_HALTED;
      end else begin
        inc[SEL_RETIRED] = 1'b1;
        case (opcode)
          OP_R:      inc[SEL_R]      = 1'b1;
          OP_I:      inc[SEL_I]      = 1'b1;
          OP_LOAD:   inc[SEL_LOAD]   = 1'b1;
          OP_STORE:  inc[SEL_STORE]  = 1'b1;
          OP_BRANCH: inc[SEL_BRANCH] = 1'b1;
          default:   inc[SEL_OTHER]  = 1'b1;
        endcase
        if ((opcode == OP_STORE) != mem_write_in) inc[SEL_MISMATCH] = 1'b1;
        if (branch_in && opcode == OP_BRANCH) begin
          pending_d = 1'b1;
          src_d     = pc_in;
        end
        stall_d = pc_same ? stall_q + STALL_W'(1) : '0;
        if (pc_same && stall_q == STALL_W'(STALL_LIMIT - 1)) state_d = ST_HUNG;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == 4'(i)) rd_mux = cnt_q[i];
    end
    if (rd_sel == SEL_STATE) rd_mux = CNT_W'(state_q);
  end

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pending_q    <= 1'b0;
      src_q        <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      stall_q      <= '0;
      rd_data      <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      src_q        <= src_d;
      prev_pc_q    <= pc_in;
      prev_valid_q <= 1'b1;
      stall_q      <= stall_d;
      rd_data      <= rd_mux;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i]) cnt_q[i] <= CNT_W'(sat_inc(64'(cnt_q[i]), CNT_W));
      end
    end
  end

  logic unused_inputs;

`ifdef RETIRE_MON_TRACE_EN
  retire_mon_trace_buf #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({src_q, pc_in}),
    .rd_idx    (tr_idx),
    .rd_data   (tr_data),
    .count     (tr_count)
  );
  assign unused_inputs = reg_write_en_in;
`else
  assign tr_data       = '0;
  assign tr_count      = '0;
  assign unused_inputs = ^{reg_write_en_in, tr_idx, push};
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor: program tables plus read-back check tables,
// with hand sequences for hang, branch trace, mid-run reset and saturation.
module tb_retire_monitor;

  localparam logic [31:0] I_ADD  = 32'h003100b3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h0000a103;
  localparam logic [31:0] I_SW   = 32'h0020a023;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_JAL  = 32'h0000006f;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  pc_in;
  logic [31:0]  instr_in;
  logic         reg_write_en_in, mem_write_in, branch_in;
  logic [3:0]   rd_sel;
  logic [31:0]  rd_data;
  logic         halted, hung;
  logic [2:0]   tr_idx;
  logic [127:0] tr_data;
  logic [3:0]   tr_count;
  logic [3:0]   rd_data_s;
  logic         halted_s, hung_s;
  logic [127:0] tr_data_s;
  logic [3:0]   tr_count_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  retire_monitor dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .reg_write_en_in(reg_write_en_in), .mem_write_in(mem_write_in), .branch_in(branch_in),
    .rd_sel(rd_sel), .rd_data(rd_data), .halted(halted), .hung(hung),
    .tr_idx(tr_idx), .tr_data(tr_data), .tr_count(tr_count)
  );

  retire_monitor #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .reg_write_en_in(reg_write_en_in), .mem_write_in(mem_write_in), .branch_in(branch_in),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .halted(halted_s), .hung(hung_s),
    .tr_idx(tr_idx), .tr_data(tr_data_s), .tr_count(tr_count_s)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        rw;
    logic        mw;
    logic        br;
  } sample_t;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] exp;
  } rd_chk_t;

  sample_t stim[$];
  rd_chk_t exps[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic sample_t smp(input logic [63:0] pc, input logic [31:0] instr,
                                  input logic rw, input logic mw, input logic br);
    sample_t s;
    s.pc = pc; s.instr = instr; s.rw = rw; s.mw = mw; s.br = br;
    return s;
  endfunction

  function automatic rd_chk_t rc(input logic [3:0] sel, input logic [31:0] exp);
    rd_chk_t c;
    c.sel = sel; c.exp = exp;
    return c;
  endfunction

  task automatic apply(input sample_t s);
    pc_in = s.pc; instr_in = s.instr; reg_write_en_in = s.rw;
    mem_write_in = s.mw; branch_in = s.br;
    @(posedge clk); #1;
  endtask

  task automatic read_cnt(input logic [3:0] sel, output logic [31:0] v);
    rd_sel = sel;
    @(posedge clk); #1;
    v = rd_data;
  endtask

  task automatic read_tr(input logic [2:0] idx, output logic [127:0] v);
    tr_idx = idx;
    @(posedge clk); #1;
    v = tr_data;
  endtask

  task automatic check_table(input string tag);
    logic [31:0] v;
    foreach (exps[i]) begin
      read_cnt(exps[i].sel, v);
      check($sformatf("%s sel%0d", tag, exps[i].sel), v, exps[i].exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pc_in = '0; instr_in = '0; reg_write_en_in = 1'b0;
    mem_write_in = 1'b0; branch_in = 1'b0; rd_sel = '0; tr_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // add, addi, lw, sw, then the halting zero word.
  task automatic load_prog1();
    stim.delete();
    stim.push_back(smp(64'h0,  I_ADD,  1'b1, 1'b0, 1'b0));
    stim.push_back(smp(64'h4,  I_ADDI, 1'b1, 1'b0, 1'b0));
    stim.push_back(smp(64'h8,  I_LW,   1'b1, 1'b0, 1'b0));
    stim.push_back(smp(64'hC,  I_SW,   1'b0, 1'b1, 1'b0));
    stim.push_back(smp(64'h10, 32'h0,  1'b0, 1'b0, 1'b0));
    exps.delete();
    exps.push_back(rc(4'd0, 5));  exps.push_back(rc(4'd1, 4));
    exps.push_back(rc(4'd2, 1));  exps.push_back(rc(4'd3, 1));
    exps.push_back(rc(4'd4, 1));  exps.push_back(rc(4'd5, 1));
    exps.push_back(rc(4'd6, 0));  exps.push_back(rc(4'd7, 0));
    exps.push_back(rc(4'd8, 0));  exps.push_back(rc(4'd9, 0));
    exps.push_back(rc(4'd10, 1)); exps.push_back(rc(4'd11, 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0]  v;
    logic [127:0] t;
    logic [63:0]  p;

    // Reset state
    do_reset();
    check("reset rd_data", rd_data, 0);
    check("reset halted", halted, 0);
    check("reset hung", hung, 0);
    check("reset tr_count", tr_count, 0);
    check("reset tr_data", tr_data, 0);

    // Straight-line program then halt; later samples must not move counters.
    load_prog1();
    for (int i = 0; i < stim.size(); i++) begin
      apply(stim[i]);
      if (i == 3) check("prog1 halted early", halted, 0);
    end
    check("prog1 halted", halted, 1);
    for (int i = 0; i < 3; i++) apply(smp(64'h100 + 64'(i * 4), I_ADD, 1'b1, 1'b0, 1'b0));
    check_table("prog1");

    // Taken, not-taken, and a taken branch resolved by the halting word.
    do_reset();
    stim.delete();
    stim.push_back(smp(64'h10, I_BEQ,  1'b0, 1'b0, 1'b1));
    stim.push_back(smp(64'h18, I_ADDI, 1'b1, 1'b0, 1'b0));
    stim.push_back(smp(64'h1C, I_BEQ,  1'b0, 1'b0, 1'b1));
    stim.push_back(smp(64'h20, I_ADDI, 1'b1, 1'b0, 1'b0));
    stim.push_back(smp(64'h24, I_BEQ,  1'b0, 1'b0, 1'b1));
    stim.push_back(smp(64'h80, 32'h0,  1'b0, 1'b0, 1'b0));
    foreach (stim[i]) apply(stim[i]);
    exps.delete();
    exps.push_back(rc(4'd0, 6)); exps.push_back(rc(4'd1, 5));
    exps.push_back(rc(4'd3, 2)); exps.push_back(rc(4'd6, 3));
    exps.push_back(rc(4'd7, 2)); exps.push_back(rc(4'd8, 0));
    exps.push_back(rc(4'd10, 1));
    check_table("branch");
    read_tr(3'd0, t);
`ifdef RETIRE_MON_TRACE_EN
    check("branch tr0", t, {64'h24, 64'h80});
    read_tr(3'd1, t);
    check("branch tr1", t, {64'h10, 64'h18});
    read_tr(3'd2, t);
    check("branch tr2 empty", t, 0);
    check("branch tr_count", tr_count, 2);
`else
    check("branch tr0 off", t, 0);
    check("branch tr_count off", tr_count, 0);
`endif

    // Mismatches, then a self-loop at 0x20 that must hang on the 17th sample.
    do_reset();
    apply(smp(64'h0, I_SW,  1'b0, 1'b0, 1'b0));
    apply(smp(64'h4, I_ADD, 1'b1, 1'b1, 1'b0));
    for (int k = 1; k <= 17; k++) begin
      apply(smp(64'h20, I_JAL, 1'b1, 1'b0, 1'b0));
      if (k == 16) check("hang not yet", hung, 0);
    end
    check("hang set", hung, 1);
    check("hang halted", halted, 0);
    for (int i = 0; i < 3; i++) apply(smp(64'h40 + 64'(i * 4), I_ADD, 1'b1, 1'b0, 1'b0));
    exps.delete();
    exps.push_back(rc(4'd0, 19)); exps.push_back(rc(4'd1, 19));
    exps.push_back(rc(4'd2, 1));  exps.push_back(rc(4'd5, 1));
    exps.push_back(rc(4'd8, 17)); exps.push_back(rc(4'd9, 2));
    exps.push_back(rc(4'd10, 2));
    check_table("hang");

    // Reset pulsed at sample 50 of a running program, then rerun prog1.
    do_reset();
    for (int i = 0; i < 49; i++) begin
      p = (i <= 10) ? 64'(i * 4) : 64'h200 + 64'(i * 4);
      apply(smp(p, (i == 10) ? I_BEQ : I_ADD, 1'b1, 1'b0, i == 10));
    end
    do_reset();
    check("midreset halted", halted, 0);
    check("midreset tr_count", tr_count, 0);
    check("midreset rd_data", rd_data, 0);
    load_prog1();
    foreach (stim[i]) apply(stim[i]);
    check_table("rerun");

    // Saturation on the 4-bit instance; also pre-increment read timing.
    do_reset();
    rd_sel = 4'd0;
    for (int i = 0; i < 20; i++) begin
      pc_in = 64'(i * 4); instr_in = I_ADD; reg_write_en_in = 1'b1;
      mem_write_in = 1'b0; branch_in = 1'b0;
      @(posedge clk); #1;
      if (i == 2) check("read pre-increment", rd_data, 2);
    end
    apply(smp(64'h400, 32'h0, 1'b0, 1'b0, 1'b0));
    read_cnt(4'd0, v);
    check("sat big cycles", v, 21);
    check("sat small cycles", rd_data_s, 15);
    read_cnt(4'd1, v);
    check("sat small retired", rd_data_s, 15);
    check("sat small halted", halted_s, 1);

    // Ten taken branches into an eight-deep trace.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      p = 64'h100 * 64'(k + 1);
      apply(smp(p, I_BEQ, 1'b0, 1'b0, 1'b1));
      apply(smp(p + 64'h40, I_ADDI, 1'b1, 1'b0, 1'b0));
    end
    apply(smp(64'h5000, 32'h0, 1'b0, 1'b0, 1'b0));
    read_cnt(4'd7, v);
    check("trace10 taken", v, 10);
    read_cnt(4'd0, v);
    check("trace10 cycles", v, 21);
    read_tr(3'd7, t);
`ifdef RETIRE_MON_TRACE_EN
    check("trace10 tr_count", tr_count, 8);
    check("trace10 idx7", t, {64'h300, 64'h340});
    read_tr(3'd0, t);
    check("trace10 idx0", t, {64'hA00, 64'hA40});
`else
    check("trace10 tr_count off", tr_count, 0);
    check("trace10 idx7 off", t, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
